// File: rtl/serial_sub_ctrl_if.sv
// Handshake and result bundle for the bit-serial subtractor controller.
// Carries the ovf result only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout, ovf
    );
    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_sub cell, LSB first, result after WIDTH shifts.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ cin;
    assign borrow = (~a & b) | (~(a ^ b) & cin);
endmodule

// state    | meaning
// ST_IDLE  | waiting for start, outputs hold last result
// ST_SHIFT | one bit pair through the cell per clock
// ST_DONE  | result just updated, done high for this cycle
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             borrow_reg;
    logic             bout_q;
    logic             cell_diff;
    logic             cell_borrow;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    full_sub u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cin    (borrow_reg),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    assign accept   = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Result bits enter from the MSB side so the first (LSB) bit lands at [0] after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            diff_q     <= '0;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            bout_q     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else if (accept) begin
            a_sr       <= bus.a_in;
            b_sr       <= bus.b_in;
            borrow_reg <= bus.bin;
            cnt        <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr       <= a_sr >> 1;
            b_sr       <= b_sr >> 1;
            borrow_reg <= cell_borrow;
            res_sr     <= {cell_diff, res_sr[WIDTH-1:1]};
            cnt        <= cnt + CW'(1);
            if (last_bit) begin
                diff_q <= {cell_diff, res_sr[WIDTH-1:1]};
                bout_q <= cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
                // Borrow into vs. out of the sign cell disagree exactly on signed overflow.
                ovf_q  <= borrow_reg ^ cell_borrow;
`endif
            end
        end
    end

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: 4-bit and 8-bit instances share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_serial_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    int         total = 0;
    int         bad = 0;

    logic [31:0] m_busy [2];
    logic [31:0] m_done [2];
    logic [31:0] m_diff [2];
    logic [31:0] m_bout [2];
    logic [31:0] p_diff [2];
    logic [31:0] p_bout [2];
    int          m_left [2];
`ifdef SERIAL_SUB_OVF_EN
    logic [31:0] m_ovf [2];
    logic [31:0] p_ovf [2];
`endif

    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(4)) if4 ();
    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();

    assign if4.start = start;
    assign if4.a_in  = a[3:0];
    assign if4.b_in  = b[3:0];
    assign if4.bin   = bin;
    assign if8.start = start;
    assign if8.a_in  = a;
    assign if8.b_in  = b;
    assign if8.bin   = bin;

    serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_diff[i] = 0; m_bout[i] = 0;
            p_diff[i] = 0; p_bout[i] = 0; m_left[i] = 0;
`ifdef SERIAL_SUB_OVF_EN
            m_ovf[i] = 0; p_ovf[i] = 0;
`endif
        end
    endtask

    // Behaviour per clock edge: accept when not busy, result appears WIDTH edges later.
    task automatic model_edge();
        int     w;
        longint mask, ai, bi, sa, sb, r, half;
        for (int i = 0; i < 2; i++) begin
            w    = (i == 0) ? 4 : 8;
            mask = (longint'(1) << w) - 1;
            half = longint'(1) << (w - 1);
            if (start && m_busy[i] == 0) begin
                ai = longint'(a) & mask;
                bi = longint'(b) & mask;
                p_diff[i] = 32'((ai - bi - longint'(bin)) & mask);
                p_bout[i] = (ai < bi + longint'(bin)) ? 1 : 0;
                sa = (ai >= half) ? ai - (mask + 1) : ai;
                sb = (bi >= half) ? bi - (mask + 1) : bi;
                r  = sa - sb - longint'(bin);
`ifdef SERIAL_SUB_OVF_EN
                p_ovf[i] = (r < -half || r > half - 1) ? 1 : 0;
`endif
                m_busy[i] = 1;
                m_done[i] = 0;
                m_left[i] = w;
            end else if (m_busy[i] != 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_busy[i] = 0;
                    m_done[i] = 1;
                    m_diff[i] = p_diff[i];
                    m_bout[i] = p_bout[i];
`ifdef SERIAL_SUB_OVF_EN
                    m_ovf[i]  = p_ovf[i];
`endif
                end else begin
                    m_done[i] = 0;
                end
            end else begin
                m_done[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("w4 busy", 32'(if4.busy), m_busy[0]);
        chk("w4 done", 32'(if4.done), m_done[0]);
        chk("w4 diff", 32'(if4.diff), m_diff[0]);
        chk("w4 bout", 32'(if4.bout), m_bout[0]);
        chk("w8 busy", 32'(if8.busy), m_busy[1]);
        chk("w8 done", 32'(if8.done), m_done[1]);
        chk("w8 diff", 32'(if8.diff), m_diff[1]);
        chk("w8 bout", 32'(if8.bout), m_bout[1]);
`ifdef SERIAL_SUB_OVF_EN
        chk("w4 ovf", 32'(if4.ovf), m_ovf[0]);
        chk("w8 ovf", 32'(if8.ovf), m_ovf[1]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) step();
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
        start = 1'b1; a = av; b = bv; bin = bv_in;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        idle(2);

        op(8'd9, 8'd5, 1'b0);
        repeat (4) step();
        chk("tp1 done", 32'(if4.done), 32'd1);
        chk("tp1 diff", 32'(if4.diff), 32'd4);
        chk("tp1 bout", 32'(if4.bout), 32'd0);
        idle(6);

        op(8'd5, 8'd9, 1'b0);
        repeat (4) step();
        chk("tp2 diff", 32'(if4.diff), 32'd12);
        chk("tp2 bout", 32'(if4.bout), 32'd1);
        idle(5);
        op(8'd0, 8'd0, 1'b1);
        repeat (3) step();
        chk("tp2 hold", 32'(if4.diff), 32'd12);
        step();
        chk("tp2b diff", 32'(if4.diff), 32'd15);
        idle(6);

        op(8'd9, 8'd5, 1'b0);
        step();
        op(8'd1, 8'd1, 1'b0);
        repeat (2) step();
        chk("tp3 diff", 32'(if4.diff), 32'd4);
        idle(8);

        start = 1'b1; a = 8'd9; b = 8'd5; bin = 1'b0;
        step();
        a = 8'd3; b = 8'd1;
        repeat (4) step();
        chk("tp4 first done", 32'(if4.done), 32'd1);
        step();
        chk("tp4 no idle", 32'(if4.busy), 32'd1);
        start = 1'b0;
        repeat (4) step();
        chk("tp4 second diff", 32'(if4.diff), 32'd2);
        idle(8);

        op(8'd200, 8'd100, 1'b0);
        repeat (3) step();
        do_reset();
        idle(10);
        op(8'd200, 8'd100, 1'b0);
        repeat (8) step();
        chk("tp5 diff", 32'(if8.diff), 32'd100);
        chk("tp5 bout", 32'(if8.bout), 32'd0);
        idle(3);

        op(8'd7, 8'd15, 1'b0);
        idle(9);
        op(8'd3, 8'd1, 1'b0);
        idle(9);

        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            bin   = 1'($urandom);
            step();
            if (n == 200) do_reset();
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
